// File: rtl/munoc_monitor_status_collector_if.sv
// ---------------------------------------------------------------------------
// munoc_monitor_status_collector_if
//   Single-cycle register port of the per-link status collector.
//   rsel   : access strobe, one cycle per access
//   rwrite : 1 = write, 0 = read
//   raddr  : register word address
//   rwdata : write data
//   rrdata : read data, registered one cycle after the read strobe
//   Modports: master = software side (drives the access),
//             slave  = collector side (returns read data).
// ---------------------------------------------------------------------------
interface munoc_monitor_status_collector_if;
  logic        rsel;
  logic        rwrite;
  logic [3:0]  raddr;
  logic [31:0] rwdata;
  logic [31:0] rrdata;

  modport master (output rsel, rwrite, raddr, rwdata, input rrdata);
  modport slave  (input rsel, rwrite, raddr, rwdata, output rrdata);
endinterface

// File: rtl/munoc_monitor_status_collector.sv
// ---------------------------------------------------------------------------
// munoc_monitor_status_collector
//   Turns the level/pulse status of one link's AXI monitor into software
//   visible state: sticky flags (W1C), saturating per-flag event counters,
//   first AXI-checker error code, bandwidth min/max and one maskable level
//   interrupt. One instance per monitored link.
//
// Ports
//   clk          : system clock
//   rstnn        : asynchronous active-low reset
//   enable       : monitor enable; no event capture while low
//   status_in    : NUM_STATUS level flags (timeout/deadlock)
//   bandwidth_in : current bandwidth sample
//   checker_in   : AXI-checker code, nonzero = violation
//   reg_if       : register port (rsel/rwrite/raddr/rwdata/rrdata)
//   interrupt    : registered level interrupt
//
// Register map (word address)
//   0x0 STICKY  RO / W1C          0x1 MASK    RW, NUM_STATUS+1 bits
//   0x2 CHECKER [31]=valid, code; any write clears
//   0x3 BW_MAX  RO; any write resets max=0, min=all-ones
//   0x4 BW_MIN  RO                0x5 TIMESTAMP (optional, else reads 0)
//   0x8+i COUNT[i]; any write clears.  Unmapped: read 0, write ignored.
//
// Optional feature: define MUNOC_STATUS_COLLECTOR_TIMESTAMP_EN to add a
// free-running timestamp counter latched on the first event after idle.
// ---------------------------------------------------------------------------
module munoc_monitor_status_collector #(
  parameter int NUM_STATUS   = 5,
  parameter int BW_COUNT     = 8,
  parameter int BW_BANDWIDTH = 16,
  parameter int BW_CHECKER   = 8,
  parameter int BW_TIMESTAMP = 32
) (
  input  logic                             clk,
  input  logic                             rstnn,
  input  logic                             enable,
  input  logic [NUM_STATUS-1:0]            status_in,
  input  logic [BW_BANDWIDTH-1:0]          bandwidth_in,
  input  logic [BW_CHECKER-1:0]            checker_in,
  munoc_monitor_status_collector_if.slave  reg_if,
  output logic                             interrupt
);

  localparam logic [3:0] ADDR_STICKY    = 4'h0;
  localparam logic [3:0] ADDR_MASK      = 4'h1;
  localparam logic [3:0] ADDR_CHECKER   = 4'h2;
  localparam logic [3:0] ADDR_BW_MAX    = 4'h3;
  localparam logic [3:0] ADDR_BW_MIN    = 4'h4;
  localparam logic [3:0] ADDR_TIMESTAMP = 4'h5;

  typedef logic [BW_COUNT-1:0] count_t;

  logic [NUM_STATUS-1:0]   prev_q, prev_d;
  logic [NUM_STATUS-1:0]   sticky_q, sticky_d;
  logic [NUM_STATUS:0]     mask_q, mask_d;
  count_t                  count_q [NUM_STATUS];
  count_t                  count_d [NUM_STATUS];
  logic [BW_CHECKER-1:0]   first_code_q, first_code_d;
  logic                    code_valid_q, code_valid_d;
  logic [BW_BANDWIDTH-1:0] bw_max_q, bw_max_d;
  logic [BW_BANDWIDTH-1:0] bw_min_q, bw_min_d;
  logic                    interrupt_q, interrupt_d;
  logic [31:0]             rrdata_q, rrdata_d;

  logic                    wr_en, rd_en;
  logic [NUM_STATUS-1:0]   evt;
  logic                    checker_hit;
  logic [31:0]             rd_mux;
  logic [31:0]             ts_rd;
  logic                    unused_rwdata;

  assign wr_en       = reg_if.rsel & reg_if.rwrite;
  assign rd_en       = reg_if.rsel & ~reg_if.rwrite;
  // Rising edges only; prev is frozen while disabled, so a flag that rose
  // during a disabled window is still reported once capture resumes.
  assign evt         = enable ? (status_in & ~prev_q) : '0;
  assign checker_hit = enable & (checker_in != '0);

  assign unused_rwdata = ^reg_if.rwdata[31:NUM_STATUS+1];

  // NOTE: combinational blocks assign every output a default first, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    prev_d = enable ? status_in : prev_q;

    // Clear first, then set: an event in the same cycle as W1C wins.
    sticky_d = sticky_q;
    if (wr_en && reg_if.raddr == ADDR_STICKY) begin
      sticky_d = sticky_q & ~reg_if.rwdata[NUM_STATUS-1:0];
    end
    sticky_d = sticky_d | evt;

    mask_d = mask_q;
    if (wr_en && reg_if.raddr == ADDR_MASK) begin
      mask_d = reg_if.rwdata[NUM_STATUS:0];
    end

    for (int i = 0; i < NUM_STATUS; i++) begin
      count_d[i] = count_q[i];
      if (wr_en && reg_if.raddr == 4'(8 + i)) begin
        count_d[i] = '0;
      end
      if (evt[i] && count_d[i] != '1) begin
        count_d[i] = count_d[i] + count_t'(1);
      end
    end

    // Capture looks at the post-clear valid so a clear and a new code in
    // the same cycle recaptures.
    first_code_d = first_code_q;
    code_valid_d = code_valid_q;
    if (wr_en && reg_if.raddr == ADDR_CHECKER) begin
      first_code_d = '0;
      code_valid_d = 1'b0;
    end
    if (checker_hit && !code_valid_d) begin
      first_code_d = checker_in;
      code_valid_d = 1'b1;
    end

    bw_max_d = bw_max_q;
    bw_min_d = bw_min_q;
    if (wr_en && reg_if.raddr == ADDR_BW_MAX) begin
      bw_max_d = '0;
      bw_min_d = '1;
    end
    if (enable) begin
      if (bandwidth_in > bw_max_d) bw_max_d = bandwidth_in;
      if (bandwidth_in < bw_min_d) bw_min_d = bandwidth_in;
    end

    interrupt_d = (|(sticky_q & mask_q[NUM_STATUS-1:0])) |
                  (code_valid_q & mask_q[NUM_STATUS]);
  end

  // Read mux: fields zero-extended into the 32-bit data word.
  always_comb begin
    rd_mux = '0;
    case (reg_if.raddr)
      ADDR_STICKY:    rd_mux[NUM_STATUS-1:0]   = sticky_q;
      ADDR_MASK:      rd_mux[NUM_STATUS:0]     = mask_q;
      ADDR_CHECKER: begin
        rd_mux[31]                             = code_valid_q;
        rd_mux[BW_CHECKER-1:0]                 = first_code_q;
      end
      ADDR_BW_MAX:    rd_mux[BW_BANDWIDTH-1:0] = bw_max_q;
      ADDR_BW_MIN:    rd_mux[BW_BANDWIDTH-1:0] = bw_min_q;
      ADDR_TIMESTAMP: rd_mux                   = ts_rd;
      default: begin
        for (int i = 0; i < NUM_STATUS; i++) begin
          if (reg_if.raddr == 4'(8 + i)) rd_mux[BW_COUNT-1:0] = count_q[i];
        end
      end
    endcase
    rrdata_d = rd_en ? rd_mux : rrdata_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      prev_q       <= '0;
      sticky_q     <= '0;
      mask_q       <= '0;
      // NOTE: the counter array is a handful of flops, not a RAM, so it is
      // reset together with the rest of the state.
      for (int i = 0; i < NUM_STATUS; i++) count_q[i] <= '0;
      first_code_q <= '0;
      code_valid_q <= 1'b0;
      bw_max_q     <= '0;
      bw_min_q     <= '1;
      interrupt_q  <= 1'b0;
      rrdata_q     <= '0;
    end else begin
      prev_q       <= prev_d;
      sticky_q     <= sticky_d;
      mask_q       <= mask_d;
      for (int i = 0; i < NUM_STATUS; i++) count_q[i] <= count_d[i];
      first_code_q <= first_code_d;
      code_valid_q <= code_valid_d;
      bw_max_q     <= bw_max_d;
      bw_min_q     <= bw_min_d;
      interrupt_q  <= interrupt_d;
      rrdata_q     <= rrdata_d;
    end
  end

`ifdef MUNOC_STATUS_COLLECTOR_TIMESTAMP_EN
  logic [BW_TIMESTAMP-1:0] ts_cnt_q, ts_cnt_d;
  logic [BW_TIMESTAMP-1:0] timestamp_q, timestamp_d;
  logic                    first_event;

  // "First" means nothing is pending: no sticky flag and no captured code.
  assign first_event = ((|evt) | checker_hit) & ~(|sticky_q) & ~code_valid_q;

  always_comb begin
    ts_cnt_d    = enable ? ts_cnt_q + BW_TIMESTAMP'(1) : ts_cnt_q;
    timestamp_d = timestamp_q;
    if (wr_en && reg_if.raddr == ADDR_TIMESTAMP) timestamp_d = '0;
    if (first_event) timestamp_d = ts_cnt_q;
    ts_rd = '0;
    ts_rd[BW_TIMESTAMP-1:0] = timestamp_q;
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      ts_cnt_q    <= '0;
      timestamp_q <= '0;
    end else begin
      ts_cnt_q    <= ts_cnt_d;
      timestamp_q <= timestamp_d;
    end
  end
`else
  localparam int unused_ts_width = BW_TIMESTAMP;
  assign ts_rd = '0;
`endif

  assign reg_if.rrdata = rrdata_q;
  assign interrupt     = interrupt_q;

endmodule
